// File: rtl/datapath_pipe.sv
// rtl/datapath_pipe.sv - three-stage mask/combine datapath with accumulator and valid/ready handshakes
// S1 captures operands, S2 masks, S3 combines per mode into the output register.
module datapath_pipe #(
    parameter int WIDTH   = 16,
    parameter bit ACC_SAT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] coeff,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             acc_ovf,
    output logic             busy
);

    localparam int HALF = WIDTH / 2;

    localparam logic [1:0] MODE_FOLD = 2'd0;
    localparam logic [1:0] MODE_PASS = 2'd1;
    localparam logic [1:0] MODE_ACC  = 2'd2;
    localparam logic [1:0] MODE_LOAD = 2'd3;

    logic             stall;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [WIDTH-1:0] s1_coeff;
    logic [1:0]       s1_mode;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_p;
    logic [1:0]       s2_mode;

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] acc_next;
    logic             ovf_next;

    // The whole pipe freezes as one unit; a held output beat blocks every stage.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign busy     = s1_valid || s2_valid || out_valid;

    assign sum = {1'b0, acc} + {1'b0, s2_p};

    always_comb begin
        result   = s2_p;
        acc_next = acc;
        ovf_next = acc_ovf;
        case (s2_mode)
            MODE_FOLD: result = s2_p ^ {s2_p[HALF-1:0], s2_p[WIDTH-1:HALF]};
            MODE_PASS: result = s2_p;
            MODE_ACC: begin
                if (sum[WIDTH] && ACC_SAT) begin
                    result = {WIDTH{1'b1}};
                end else begin
                    result = sum[WIDTH-1:0];
                end
                acc_next = result;
                ovf_next = acc_ovf || sum[WIDTH];
            end
            MODE_LOAD: begin
                result   = s2_p;
                acc_next = s2_p;
                ovf_next = 1'b0;
            end
            default: result = s2_p;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_coeff  <= '0;
            s1_mode   <= '0;
            s2_valid  <= 1'b0;
            s2_p      <= '0;
            s2_mode   <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data  <= data_in;
                s1_coeff <= coeff;
                s1_mode  <= mode;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_p    <= s1_data & s1_coeff;
                s2_mode <= s1_mode;
            end
            out_valid <= s2_valid;
            // Accumulator moves only with a beat entering the output register.
            if (s2_valid) begin
                data_out <= result;
                acc      <= acc_next;
                acc_ovf  <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_datapath_pipe.sv
// tb/tb_datapath_pipe.sv - directed vector bench for datapath_pipe, wrap and saturate instances
// Both instances share stimulus; expectations are hand-computed per instance.
module tb_datapath_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] data_in;
    logic [15:0] coeff;
    logic [1:0]  mode;
    logic        out_ready;

    logic        rdy0, ov0, ovf0, busy0;
    logic [15:0] dout0;
    logic        rdy1, ov1, ovf1, busy1;
    logic [15:0] dout1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    datapath_pipe #(.WIDTH(16), .ACC_SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .data_in(data_in), .coeff(coeff), .mode(mode),
        .out_valid(ov0), .out_ready(out_ready), .data_out(dout0),
        .acc_ovf(ovf0), .busy(busy0)
    );

    datapath_pipe #(.WIDTH(16), .ACC_SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .data_in(data_in), .coeff(coeff), .mode(mode),
        .out_valid(ov1), .out_ready(out_ready), .data_out(dout1),
        .acc_ovf(ovf1), .busy(busy1)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] data;
        logic [15:0] coeff;
        logic [15:0] exp0;
        logic        eovf0;
        logic [15:0] exp1;
        logic        eovf1;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat through an idle pipe; returns edges from accept to out_valid.
    task automatic send_one(input logic [1:0] m, input logic [15:0] d, input logic [15:0] c,
                            output int lat);
        mode     = m;
        data_in  = d;
        coeff    = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!ov0 && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    int          lat;
    int          idx;
    int          nrecv;
    logic [15:0] recv[$];
    logic [15:0] held;
    logic        prev_stall;
    logic        saw_stall;
    logic        acc_now;
    logic        out_now;
    int          stray;

    initial begin
        vecs[0]  = '{2'd0, 16'hFFFF, 16'h00FF, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
        vecs[1]  = '{2'd1, 16'h1234, 16'h0F0F, 16'h0204, 1'b0, 16'h0204, 1'b0};
        vecs[2]  = '{2'd3, 16'hFFF0, 16'hFFFF, 16'hFFF0, 1'b0, 16'hFFF0, 1'b0};
        vecs[3]  = '{2'd2, 16'h0020, 16'hFFFF, 16'h0010, 1'b1, 16'hFFFF, 1'b1};
        vecs[4]  = '{2'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
        vecs[5]  = '{2'd2, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
        vecs[6]  = '{2'd2, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
        vecs[7]  = '{2'd2, 16'h0003, 16'hFFFF, 16'h0003, 1'b1, 16'hFFFF, 1'b1};
        vecs[8]  = '{2'd1, 16'hABCD, 16'hFF00, 16'hAB00, 1'b1, 16'hAB00, 1'b1};
        vecs[9]  = '{2'd0, 16'h1234, 16'hFFFF, 16'h2626, 1'b1, 16'h2626, 1'b1};
        vecs[10] = '{2'd3, 16'h0100, 16'h0F00, 16'h0100, 1'b0, 16'h0100, 1'b0};
        vecs[11] = '{2'd2, 16'h00FF, 16'h00F0, 16'h01F0, 1'b0, 16'h01F0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        coeff     = '0;
        mode      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, rdy0}, 32'd1);
        check("rst_out_valid", {31'd0, ov0}, 32'd0);
        check("rst_data_out", {16'd0, dout0}, 32'd0);
        check("rst_acc_ovf", {31'd0, ovf0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_sat_busy", {31'd0, busy1}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            send_one(vecs[i].mode, vecs[i].data, vecs[i].coeff, lat);
            check($sformatf("vec%0d_latency", i), lat, 32'd3);
            check($sformatf("vec%0d_wrap_out", i), {16'd0, dout0}, {16'd0, vecs[i].exp0});
            check($sformatf("vec%0d_wrap_ovf", i), {31'd0, ovf0}, {31'd0, vecs[i].eovf0});
            check($sformatf("vec%0d_sat_out", i), {16'd0, dout1}, {16'd0, vecs[i].exp1});
            check($sformatf("vec%0d_sat_ovf", i), {31'd0, ovf1}, {31'd0, vecs[i].eovf1});
            tick();
            check($sformatf("vec%0d_drained", i), {31'd0, ov0}, 32'd0);
        end

        // Backpressure: stream 1..8, sink stalls in cycles 4-8.
        idx        = 0;
        prev_stall = 1'b0;
        saw_stall  = 1'b0;
        held       = '0;
        mode       = 2'd1;
        coeff      = 16'hFFFF;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 4 && c <= 8);
            in_valid  = (idx < 8);
            data_in   = 16'(idx + 1);
            #1;
            acc_now = in_valid && rdy0;
            out_now = ov0 && out_ready;
            if (ov0 && !out_ready) begin
                if (!saw_stall) check("bp_in_ready_low", {31'd0, rdy0}, 32'd0);
                if (prev_stall) check($sformatf("bp_hold_c%0d", c), {16'd0, dout0}, {16'd0, held});
                saw_stall = 1'b1;
            end
            prev_stall = ov0 && !out_ready;
            held       = dout0;
            if (out_now) recv.push_back(dout0);
            tick();
            if (acc_now) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_saw_stall", {31'd0, saw_stall}, 32'd1);
        nrecv = recv.size();
        check("bp_count", nrecv, 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < nrecv) check($sformatf("bp_order%0d", k), {16'd0, recv[k]}, k + 1);
        end

        // Reset with beats in flight: preload acc, then kill three mode-2 beats.
        send_one(2'd3, 16'h1000, 16'hFFFF, lat);
        check("mid_preload", {16'd0, dout0}, 32'h1000);
        tick();
        stray = 0;
        mode  = 2'd2;
        coeff = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            data_in  = 16'h0100;
            rst      = (c == 2);
            if (ov0) stray++;
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (ov0) stray++;
            tick();
        end
        check("mid_no_output", stray, 32'd0);
        check("mid_busy", {31'd0, busy0}, 32'd0);
        check("mid_data_out", {16'd0, dout0}, 32'd0);
        send_one(2'd2, 16'h0005, 16'hFFFF, lat);
        check("mid_latency", lat, 32'd3);
        check("mid_acc_zero", {16'd0, dout0}, 32'h0005);
        check("mid_acc_ovf", {31'd0, ovf0}, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
